pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Controller at the far end of the PLL reset/lock interface: drives the PLL reset, watches its asynchronous lock indication, and releases the downstream system reset only after lock has been stable for a hold window. Lives in the free-running reference-clock domain beside the PLL wrapper. Retries timed-out lock attempts, re-sequences on lock loss, and latches a fault after repeated failures.

## Interface
- RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥2)
- LOCK_TIMEOUT, 10000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 10 MHz)
- LOCK_HOLD, 1000: consecutive synchronized-lock cycles required before RUN (≥1)
- MAX_RETRIES, 3: failed attempts before FAULT (1..15)
- CNT_W, 8: width of `loss_count`

- refclk  in  1  free-running reference clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- pll_locked  in  1  PLL lock, asynchronous to refclk
- relock_req  in  1  single-cycle request to restart sequencing / clear fault
- pll_rst  out  1  active-high PLL reset, registered
- sys_rst_n  out  1  active-low downstream reset, registered
- lock_ok  out  1  high while in RUN
- fault  out  1  sticky; high in FAULT
- loss_count  out  CNT_W  saturating count of lock losses in RUN
- state  out  3  current state encoding, debug

## Operation
- `pll_locked` passes through a 2-flop synchronizer → `locked_s`; the FSM uses only `locked_s`.
- States: RESET, WAIT_LOCK, SETTLE, RUN, FAULT. One shared cycle counter `cnt`, cleared on every state entry; retry counter `retries`.
- RESET: `pll_rst`=1, `sys_rst_n`=0. After RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. If `locked_s`=1 → SETTLE. If `cnt` reaches LOCK_TIMEOUT-1 with no lock, `retries`++. If the new value equals MAX_RETRIES → FAULT, otherwise → RESET.
- SETTLE: `cnt` counts cycles with `locked_s`=1.
  - `locked_s`=0 → WAIT_LOCK; timeout restarts and `retries` is unchanged.
  - `cnt`=LOCK_HOLD-1 with lock still present → RUN, and `retries` clears.
- RUN: `sys_rst_n`=1, `lock_ok`=1. Any cycle with `locked_s`=0 (even a single cycle) → RESET. `sys_rst_n` falls in the same cycle RESET is entered, and `loss_count` increments, saturating at all-ones.
- FAULT: `pll_rst`=1, `sys_rst_n`=0, `fault`=1. Stays until `relock_req`.
- `relock_req`: from any state → RESET, `retries`=0, `fault`=0. In RESET it restarts the RST_CYCLES count.
- Simultaneous `relock_req` and lock loss in RUN: `relock_req` wins the transition, and the loss is still counted.
- `rst_n`=0 at any time, including mid-sequence: immediate return to reset values below; the synchronizer flops also clear.

## Timing
- Reset values: state RESET, `pll_rst`=1, `sys_rst_n`=0, `lock_ok`=0, `fault`=0, `loss_count`=0, `retries`=0, `cnt`=0.
- Outputs are registered and decoded from the next state, so they change in the same cycle as `state`.
- After `rst_n` rises, `pll_rst` stays high for exactly RST_CYCLES cycles.
- `pll_locked` rising at edge t → `locked_s` at t+2 → SETTLE at t+3 → RUN and `sys_rst_n`=1 at t+3+LOCK_HOLD.
- `pll_locked` falling in RUN at edge t → `sys_rst_n`=0, RESET, `loss_count`+1 at t+3.
- Worst-case time to FAULT: MAX_RETRIES × (RST_CYCLES + LOCK_TIMEOUT) cycles.

## Configuration
- PLL_SUP_LOSS_COUNT_EN
  - Defined: `loss_count` counter is implemented as described.
  - Undefined: counter logic is removed and `loss_count` is tied to 0. FSM behaviour is identical.

## Structure
- Package `pll_sup_pkg`: state enum (RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4) and a 3-bit state width constant.
- Sub-module `bit_sync_2ff`: generic 2-flop synchronizer with synchronous active-low reset, used for `pll_locked`.

## Test plan
- `pll_locked` rises 50 cycles after `rst_n` release with RST_CYCLES=16, LOCK_HOLD=1000 → `pll_rst` high cycles 0–15; `sys_rst_n`=1 exactly 1003 cycles after the lock edge.
- `pll_locked` stuck at 0, LOCK_TIMEOUT=100, MAX_RETRIES=3 → three `pll_rst` pulses; `fault`=1 at cycle 3×116; then `relock_req` → RESET and `fault`=0.
- Lock drops for 1 cycle at SETTLE cycle 500 → returns to WAIT_LOCK, `retries` unchanged; on relock a full 1000-cycle hold is required again.
- In RUN, 3-cycle drop of `pll_locked` → `sys_rst_n`=0 three cycles later, `loss_count`=1, full re-sequence; with CNT_W=2, five losses → `loss_count`=3 (saturated).
- `relock_req` in the same cycle as a `locked_s` drop in RUN → RESET, `loss_count`+1, `retries`=0.
- `rst_n` asserted during SETTLE → all outputs at reset values on the next edge; macro undefined → `loss_count`=0 throughout.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: the sequencing state encoding
// and a small helper used to size the shared cycle counter.
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Largest of three cycle limits, used to size the shared state counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. Both flops clear
// on the synchronous active-low reset so stale lock history never leaks
// across a reset.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, waits for a stable lock,
// then releases the downstream reset. Retries timed-out attempts, restarts
// on lock loss and latches FAULT after MAX_RETRIES failed attempts.
// Optional feature macro: PLL_SUP_LOSS_COUNT_EN enables the saturating
// lock-loss counter; without it loss_count is tied to zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 10000,
  parameter int LOCK_HOLD    = 1000,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 8
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               lock_ok,
  output logic               fault,
  output logic [CNT_W-1:0]   loss_count,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX  = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_HOLD);
  localparam int CNT_BITS = $clog2(CNT_MAX + 1);

  localparam logic [CNT_BITS-1:0] RST_LAST  = CNT_BITS'(RST_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TO_LAST   = CNT_BITS'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(LOCK_HOLD - 1);
  localparam logic [3:0]          MAX_R     = 4'(MAX_RETRIES);

  pll_state_t          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]          retries_q, retries_d;
  logic [3:0]          retries_inc;
  logic                locked_s;
  logic                loss_event;

  bit_sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign retries_inc = retries_q + 4'd1;

  // Next-state, counter and retry decisions; relock_req overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retries_d  = retries_q;
    loss_event = 1'b0;
    case (state_q)
      RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = SETTLE;
        end else if (cnt_q == TO_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == MAX_R) ? FAULT : RESET;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = RUN;
          retries_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = RESET;
          loss_event = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET;
      end
    endcase
    // A relock request still lets a simultaneous lock loss be counted above.
    if (relock_req) begin
      state_d   = RESET;
      retries_d = '0;
    end
    // Counter restarts on every state entry, including RESET re-entered by relock.
    if (relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == RESET) || (state_q == WAIT_LOCK) || (state_q == SETTLE)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // State register with outputs decoded from the next state so they move with it.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q   <= RESET;
      cnt_q     <= '0;
      retries_q <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_ok   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      pll_rst   <= (state_d == RESET) || (state_d == FAULT);
      sys_rst_n <= (state_d == RUN);
      lock_ok   <= (state_d == RUN);
      fault     <= (state_d == FAULT);
    end
  end

  assign state = state_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_q;

  // Saturating count of lock losses observed while running.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != {CNT_W{1'b1}})) begin
      loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
  assign loss_count        = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a table of {inputs, cycles to advance,
// expected outputs} records applied in order, with expectations pushed to
// a scoreboard queue at drive time and popped when the outputs are sampled.
module tb_pll_lock_supervisor;

  localparam int RST  = 16;
  localparam int TO   = 100;
  localparam int HOLD = 1000;
  localparam int MR   = 3;
  localparam int CW   = 2;

  localparam logic [2:0] S_R = 3'd0;
  localparam logic [2:0] S_W = 3'd1;
  localparam logic [2:0] S_S = 3'd2;
  localparam logic [2:0] S_U = 3'd3;
  localparam logic [2:0] S_F = 3'd4;

  typedef struct {
    int         n;
    logic       rst_n;
    logic       lk;
    logic       rq;
    logic [2:0] st;
    logic       prst;
    logic       sys;
    logic       ok;
    logic       flt;
    int         loss;
  } vec_t;

  typedef struct {
    logic [2:0]    st;
    logic          prst;
    logic          sys;
    logic          ok;
    logic          flt;
    logic [CW-1:0] loss;
    string         tag;
  } exp_t;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          lock_ok;
  logic          fault;
  logic [CW-1:0] loss_count;
  logic [2:0]    state;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];
  int   split;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TO),
    .LOCK_HOLD    (HOLD),
    .MAX_RETRIES  (MR),
    .CNT_W        (CW)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_ok    (lock_ok),
    .fault      (fault),
    .loss_count (loss_count),
    .state      (state)
  );

  always #5 refclk = ~refclk;

  function automatic int el(input int v);
`ifdef PLL_SUP_LOSS_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic vec_t mk(input int n, input logic r, input logic lk, input logic rq,
                              input logic [2:0] st, input logic prst, input logic sys,
                              input logic ok, input logic flt, input int loss);
    vec_t v;
    v.n = n; v.rst_n = r; v.lk = lk; v.rq = rq;
    v.st = st; v.prst = prst; v.sys = sys; v.ok = ok; v.flt = flt; v.loss = loss;
    return v;
  endfunction

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expected entry queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("state", e.tag, 32'(state), 32'(e.st));
      chk("pll_rst", e.tag, 32'(pll_rst), 32'(e.prst));
      chk("sys_rst_n", e.tag, 32'(sys_rst_n), 32'(e.sys));
      chk("lock_ok", e.tag, 32'(lock_ok), 32'(e.ok));
      chk("fault", e.tag, 32'(fault), 32'(e.flt));
      chk("loss_count", e.tag, 32'(loss_count), 32'(e.loss));
    end
  endtask

  // Drive one record, advance its cycle count (relock is a one-cycle pulse), compare.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    rst_n      = v.rst_n;
    pll_locked = v.lk;
    relock_req = v.rq;
    e.st = v.st; e.prst = v.prst; e.sys = v.sys; e.ok = v.ok; e.flt = v.flt;
    e.loss = CW'(v.loss);
    e.tag  = tag;
    sb.push_back(e);
    for (int i = 0; i < v.n; i++) begin
      @(posedge refclk);
      #1;
      relock_req = 1'b0;
    end
    check_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;

    // Reset, first lock 50 cycles after release, first loss and re-sequence.
    vecs.push_back(mk(3,        0, 0, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(RST - 1,  1, 0, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 0, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(34,       1, 0, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2,        1, 1, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(HOLD - 1, 1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_U, 0, 1, 1, 0, 0));
    vecs.push_back(mk(50,       1, 1, 0, S_U, 0, 1, 1, 0, 0));
    vecs.push_back(mk(2,        1, 0, 0, S_U, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1,        1, 0, 0, S_R, 1, 0, 0, 0, el(1)));
    vecs.push_back(mk(RST,      1, 1, 0, S_W, 0, 0, 0, 0, el(1)));
    vecs.push_back(mk(1,        1, 1, 0, S_S, 0, 0, 0, 0, el(1)));
    vecs.push_back(mk(HOLD,     1, 1, 0, S_U, 0, 1, 1, 0, el(1)));
    split = vecs.size();

    // Timeout retries to FAULT, relock clears fault and retries.
    vecs.push_back(mk(2,                0, 0, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(RST + TO,         1, 0, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2*(RST + TO) - 1, 1, 0, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,                1, 0, 0, S_F, 1, 0, 0, 1, 0));
    vecs.push_back(mk(20,               1, 0, 0, S_F, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1,                1, 0, 1, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(MR*(RST + TO) - 1, 1, 0, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,                1, 0, 0, S_F, 1, 0, 0, 1, 0));
    // One-cycle lock glitch around SETTLE cycle 500 demands a fresh full hold.
    vecs.push_back(mk(1,        1, 1, 1, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(RST,      1, 1, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(500,      1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 0, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(HOLD - 1, 1, 1, 0, S_S, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,        1, 1, 0, S_U, 0, 1, 1, 0, 0));
    // Relock in the same cycle the synchronized lock drops in RUN.
    vecs.push_back(mk(2,                1, 0, 0, S_U, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1,                1, 0, 1, S_R, 1, 0, 0, 0, el(1)));
    vecs.push_back(mk(MR*(RST + TO) - 1, 1, 0, 0, S_W, 0, 0, 0, 0, el(1)));
    vecs.push_back(mk(1,                1, 0, 0, S_F, 1, 0, 0, 1, el(1)));
    // rst_n asserted during SETTLE returns everything to reset values.
    vecs.push_back(mk(1,       1, 1, 1, S_R, 1, 0, 0, 0, el(1)));
    vecs.push_back(mk(RST + 1, 1, 1, 0, S_S, 0, 0, 0, 0, el(1)));
    vecs.push_back(mk(1,       0, 1, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2,       0, 1, 0, S_R, 1, 0, 0, 0, 0));
    vecs.push_back(mk(RST,     1, 1, 0, S_W, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,       1, 1, 0, S_S, 0, 0, 0, 0, 0));

    for (int i = 0; i < split; i++) apply(vecs[i], $sformatf("row%0d", i));

    // Four more 3-cycle losses in RUN: counter saturates at 3 after the fifth.
    for (int k = 2; k <= 5; k++) begin
      apply(mk(3, 1, 0, 0, S_R, 1, 0, 0, 0, el((k > 3) ? 3 : k)), $sformatf("loss%0d_drop", k));
      apply(mk(RST + 1 + HOLD, 1, 1, 0, S_U, 0, 1, 1, 0, el((k > 3) ? 3 : k)),
            $sformatf("loss%0d_run", k));
    end

    for (int i = split; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
